// File: rtl/bcd_key_entry.sv
// bcd_key_entry
// Keypad entry accumulator for the calculator input unit. It collects decoded
// key presses into a signed operand of up to three digits. Entry is limited to
// the signed 8-bit range -128..+127. The operand is shown as packed BCD, with
// nibble E as a minus marker just left of the most significant digit. A
// finished operand is handed downstream with a valid/ready handshake.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_valid   one-cycle strobe qualifying key_code
//   key_code    0-9 digit, or one of the KEY_* control codes; other codes ignored
//   out_ready   downstream accepts the finalised operand
//   bcd         live packed-BCD operand with sign marker
//   out_valid   operand finalised; bcd frozen until out_ready is sampled
//   digit_count significant digits entered, 0..3
//   neg         sign flag
//   key_err     one-cycle pulse for a rejected key
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_EMPTY  | nothing entered: count=0, neg=0
// ST_ENTRY  | digits and/or sign being edited
// ST_LOCKED | operand finalised, out_valid high, waiting for out_ready

module bcd_key_entry #(
    parameter logic [3:0]  KEY_MINUS = 4'hA,
    parameter logic [3:0]  KEY_BACK  = 4'hB,
    parameter logic [3:0]  KEY_CLEAR = 4'hC,
    parameter logic [3:0]  KEY_ENTER = 4'hF,
    parameter int unsigned MAX_POS   = 127,
    parameter int unsigned MAX_NEG   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        out_ready,
    output logic [15:0] bcd,
    output logic        out_valid,
    output logic [1:0]  digit_count,
    output logic        neg,
    output logic        key_err
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  d2_q, d2_d;
    logic [3:0]  d1_q, d1_d;
    logic [3:0]  d0_q, d0_d;
    logic [1:0]  count_q, count_d;
    logic        neg_q, neg_d;
    logic        out_valid_q, out_valid_d;
    logic        key_err_q, key_err_d;
    logic [15:0] bcd_q;

    logic        is_digit;
    logic [9:0]  cand;
    logic [9:0]  mag;
    logic [9:0]  limit;

    // The minus marker occupies the nibble just above the top significant digit.
    function automatic logic [15:0] compose(input logic [1:0] cnt, input logic n,
                                            input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
        logic [3:0] sm;
        sm = n ? 4'hE : 4'h0;
        case (cnt)
            2'd3:    compose = {sm, a, b, c};
            2'd2:    compose = {4'h0, sm, b, c};
            2'd1:    compose = {8'h00, sm, c};
            default: compose = {12'h000, sm};
        endcase
    endfunction

    assign is_digit = (key_code <= 4'd9);
    // Candidate value when a third digit is appended to the current two.
    assign cand  = ({6'd0, d1_q} * 10'd100) + ({6'd0, d0_q} * 10'd10) + {6'd0, key_code};
    assign mag   = ({6'd0, d2_q} * 10'd100) + ({6'd0, d1_q} * 10'd10) + {6'd0, d0_q};
    assign limit = neg_q ? MAX_NEG[9:0] : MAX_POS[9:0];

    always_comb begin
        state_d     = state_q;
        d2_d        = d2_q;
        d1_d        = d1_q;
        d0_d        = d0_q;
        count_d     = count_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        key_err_d   = 1'b0;

        if (state_q == ST_LOCKED) begin
            // Keys are dropped while locked, even on the accept edge.
            if (out_ready) begin
                state_d     = ST_EMPTY;
                d2_d        = 4'h0;
                d1_d        = 4'h0;
                d0_d        = 4'h0;
                count_d     = 2'd0;
                neg_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        end else if (key_valid) begin
            if (is_digit) begin
                case (count_q)
                    2'd0: begin
                        // Leading zero leaves the entry untouched.
                        if (key_code != 4'd0) begin
                            d0_d    = key_code;
                            count_d = 2'd1;
                            state_d = ST_ENTRY;
                        end
                    end
                    2'd1: begin
                        d1_d    = d0_q;
                        d0_d    = key_code;
                        count_d = 2'd2;
                        state_d = ST_ENTRY;
                    end
                    2'd2: begin
                        if (cand <= limit) begin
                            d2_d    = d1_q;
                            d1_d    = d0_q;
                            d0_d    = key_code;
                            count_d = 2'd3;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    default: key_err_d = 1'b1;
                endcase
            end else if (key_code == KEY_MINUS) begin
                // Going positive from a magnitude only legal when negative is refused.
                if (neg_q && (mag > MAX_POS[9:0])) begin
                    key_err_d = 1'b1;
                end else begin
                    neg_d   = ~neg_q;
                    state_d = (count_q == 2'd0 && neg_q) ? ST_EMPTY : ST_ENTRY;
                end
            end else if (key_code == KEY_BACK) begin
                if (count_q != 2'd0) begin
                    d0_d    = d1_q;
                    d1_d    = d2_q;
                    d2_d    = 4'h0;
                    count_d = count_q - 2'd1;
                    state_d = (count_q == 2'd1 && !neg_q) ? ST_EMPTY : ST_ENTRY;
                end else if (neg_q) begin
                    neg_d   = 1'b0;
                    state_d = ST_EMPTY;
                end
            end else if (key_code == KEY_CLEAR) begin
                d2_d    = 4'h0;
                d1_d    = 4'h0;
                d0_d    = 4'h0;
                count_d = 2'd0;
                neg_d   = 1'b0;
                state_d = ST_EMPTY;
            end else if (key_code == KEY_ENTER) begin
                state_d     = ST_LOCKED;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            d2_q        <= 4'h0;
            d1_q        <= 4'h0;
            d0_q        <= 4'h0;
            count_q     <= 2'd0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            bcd_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            d2_q        <= d2_d;
            d1_q        <= d1_d;
            d0_q        <= d0_d;
            count_q     <= count_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            key_err_q   <= key_err_d;
            bcd_q       <= compose(count_d, neg_d, d2_d, d1_d, d0_d);
        end
    end

    assign bcd         = bcd_q;
    assign out_valid   = out_valid_q;
    assign digit_count = count_q;
    assign neg         = neg_q;
    assign key_err     = key_err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
module tb_bcd_key_entry;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        out_ready;
    logic [15:0] bcd;
    logic        out_valid;
    logic [1:0]  digit_count;
    logic        neg;
    logic        key_err;

    int n_cmp;
    int n_fail;

    bcd_key_entry dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .out_ready   (out_ready),
        .bcd         (bcd),
        .out_valid   (out_valid),
        .digit_count (digit_count),
        .neg         (neg),
        .key_err     (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        rdy;
        logic [15:0] bcd;
        logic        ov;
        logic [1:0]  cnt;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic kv, input logic [3:0] code, input logic rdy,
                       input logic [15:0] b, input logic ov, input logic [1:0] cnt,
                       input logic n, input logic err);
        vec_t v;
        v.kv = kv; v.code = code; v.rdy = rdy;
        v.bcd = b; v.ov = ov; v.cnt = cnt; v.neg = n; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] eb, input logic eov,
                             input logic [1:0] ecnt, input logic en, input logic eerr);
        check({tag, " bcd"},         bcd,                eb);
        check({tag, " out_valid"},   16'(out_valid),     16'(eov));
        check({tag, " digit_count"}, 16'(digit_count),   16'(ecnt));
        check({tag, " neg"},         16'(neg),           16'(en));
        check({tag, " key_err"},     16'(key_err),       16'(eerr));
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic kv, input logic [3:0] code, input logic rdy);
        key_valid = kv;
        key_code  = code;
        out_ready = rdy;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        out_ready = 1'b0;

        //   kv code  rdy  bcd      ov cnt  neg err
        // +127, digit rejected at count 3, ENTER, held 5 cycles, key in hold
        add(1, 4'h1, 0, 16'h0001, 0, 2'd1, 0, 0);
        add(1, 4'h2, 0, 16'h0012, 0, 2'd2, 0, 0);
        add(1, 4'h7, 0, 16'h0127, 0, 2'd3, 0, 0);
        add(1, 4'h4, 0, 16'h0127, 0, 2'd3, 0, 1);
        add(1, 4'hF, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(0, 4'h0, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(0, 4'h0, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(1, 4'h5, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(0, 4'h0, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(0, 4'h0, 0, 16'h0127, 1, 2'd3, 0, 0);
        add(1, 4'h3, 1, 16'h0000, 0, 2'd0, 0, 0);
        add(0, 4'h0, 0, 16'h0000, 0, 2'd0, 0, 0);
        // -128 boundary: accepted, then MINUS and a digit both rejected
        add(1, 4'hA, 0, 16'h000E, 0, 2'd0, 1, 0);
        add(1, 4'h1, 0, 16'h00E1, 0, 2'd1, 1, 0);
        add(1, 4'h2, 0, 16'h0E12, 0, 2'd2, 1, 0);
        add(1, 4'h8, 0, 16'hE128, 0, 2'd3, 1, 0);
        add(1, 4'hA, 0, 16'hE128, 0, 2'd3, 1, 1);
        add(0, 4'h0, 0, 16'hE128, 0, 2'd3, 1, 0);
        add(1, 4'h5, 0, 16'hE128, 0, 2'd3, 1, 1);
        add(0, 4'h0, 0, 16'hE128, 0, 2'd3, 1, 0);
        add(1, 4'hC, 0, 16'h0000, 0, 2'd0, 0, 0);
        // +128 rejected
        add(1, 4'h1, 0, 16'h0001, 0, 2'd1, 0, 0);
        add(1, 4'h2, 0, 16'h0012, 0, 2'd2, 0, 0);
        add(1, 4'h8, 0, 16'h0012, 0, 2'd2, 0, 1);
        add(0, 4'h0, 0, 16'h0012, 0, 2'd2, 0, 0);
        add(1, 4'hC, 0, 16'h0000, 0, 2'd0, 0, 0);
        // -42 backspaced away, then empty ENTER
        add(1, 4'hA, 0, 16'h000E, 0, 2'd0, 1, 0);
        add(1, 4'h4, 0, 16'h00E4, 0, 2'd1, 1, 0);
        add(1, 4'h2, 0, 16'h0E42, 0, 2'd2, 1, 0);
        add(1, 4'hB, 0, 16'h00E4, 0, 2'd1, 1, 0);
        add(1, 4'hB, 0, 16'h000E, 0, 2'd0, 1, 0);
        add(1, 4'hB, 0, 16'h0000, 0, 2'd0, 0, 0);
        add(1, 4'hB, 0, 16'h0000, 0, 2'd0, 0, 0);
        add(1, 4'hF, 0, 16'h0000, 1, 2'd0, 0, 0);
        add(0, 4'h0, 1, 16'h0000, 0, 2'd0, 0, 0);
        // leading zeros, ignored code, clear, then -0 entry
        add(1, 4'h0, 0, 16'h0000, 0, 2'd0, 0, 0);
        add(1, 4'h0, 0, 16'h0000, 0, 2'd0, 0, 0);
        add(1, 4'h5, 0, 16'h0005, 0, 2'd1, 0, 0);
        add(1, 4'hD, 0, 16'h0005, 0, 2'd1, 0, 0);
        add(1, 4'hC, 0, 16'h0000, 0, 2'd0, 0, 0);
        add(1, 4'hA, 0, 16'h000E, 0, 2'd0, 1, 0);
        add(1, 4'hF, 0, 16'h000E, 1, 2'd0, 1, 0);
        add(0, 4'h0, 1, 16'h0000, 0, 2'd0, 0, 0);

        #12;
        check_all("reset", 16'h0000, 0, 2'd0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kv, vecs[i].code, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].ov,
                      vecs[i].cnt, vecs[i].neg, vecs[i].err);
        end

        // Asynchronous reset in the middle of an entry, sampled before any edge.
        step(1, 4'h4, 0);
        step(1, 4'h2, 0);
        check_all("pre_reset", 16'h0042, 0, 2'd1 + 2'd1, 0, 0);
        rst_n = 1'b0;
        #2;
        check_all("async_reset", 16'h0000, 0, 2'd0, 0, 0);
        #2;
        rst_n = 1'b1;
        step(1, 4'h9, 0);
        check_all("after_reset", 16'h0009, 0, 2'd1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
